// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and width helper.
// Anything that decodes the `state` readout (LEDs, debug) should import this package.
package pll_reset_sequencer_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states; the encoding is visible on the `state` output port.
    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILISE = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } pll_state_e;

    // Bits needed to hold 0..n-1. Never returns 0, so single-value counters stay legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, with synchronous active-low clear.
// Ports:
//   clk      in  1  sampling clock
//   clear_n  in  1  synchronous active-low clear, empties the chain to 0
//   d        in  1  asynchronous input level
//   q        out 1  synchronised level, STAGES edges after d is first sampled
module pll_reset_sequencer_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Bit 0 is the metastability-exposed capture flop; q comes from the last stage.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Releases the system reset once the PLL lock flag has been continuously stable,
// then holds a fixed tail. Also drives a heartbeat, a lock-loss counter and a state readout.
// Ports:
//   global_clock     in   1       sole clock (PLL global-buffered output)
//   resetn           in   1       synchronous active-low reset
//   locked           in   1       PLL lock flag, asynchronous
//   sys_resetn       out  1       registered system reset, high only in RUN
//   heartbeat        out  1       toggles every HEARTBEAT_DIV cycles in RUN, else 0
//   lock_loss_count  out  LOSS_W  saturating count of RUN -> WAIT_LOCK lock drops
//   state            out  2       current FSM state (pll_state_e encoding)
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned HEARTBEAT_DIV = 48_000_000,
    parameter int unsigned LOSS_W        = 8
) (
    input  logic              global_clock,
    input  logic              resetn,
    input  logic              locked,
    output logic              sys_resetn,
    output logic              heartbeat,
    output logic [LOSS_W-1:0] lock_loss_count,
    output logic [1:0]        state
);

    localparam int unsigned CNT_W = cnt_width((STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES);
    localparam int unsigned HB_W  = cnt_width(HEARTBEAT_DIV);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [HB_W-1:0]  HB_LAST     = HB_W'(HEARTBEAT_DIV - 1);

    logic              locked_s;
    pll_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
    logic              heartbeat_q, heartbeat_d;
    logic              sys_resetn_q, sys_resetn_d;
    logic [LOSS_W-1:0] loss_q, loss_d;

    pll_reset_sequencer_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (global_clock),
        .clear_n (resetn),
        .d       (locked),
        .q       (locked_s)
    );

    // State register plus all registered outputs.
    always_ff @(posedge global_clock) begin
        if (!resetn) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            hb_cnt_q     <= '0;
            heartbeat_q  <= 1'b0;
            sys_resetn_q <= 1'b0;
            loss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hb_cnt_q     <= hb_cnt_d;
            heartbeat_q  <= heartbeat_d;
            sys_resetn_q <= sys_resetn_d;
            loss_q       <= loss_d;
        end
    end

    // Next state; a lost lock wins over a counter reaching its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = ST_STABILISE;
                end
            end
            ST_STABILISE: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values are derived from the transition so they change on the same edge as the state.
    always_comb begin
        sys_resetn_d = (state_d == ST_RUN);
        hb_cnt_d     = '0;
        heartbeat_d  = 1'b0;
        loss_d       = loss_q;

        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d    = '0;
                heartbeat_d = ~heartbeat_q;
            end else begin
                hb_cnt_d    = hb_cnt_q + HB_W'(1);
                heartbeat_d = heartbeat_q;
            end
        end

        if (state_q == ST_RUN && state_d == ST_WAIT_LOCK && loss_q != '1) begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    assign sys_resetn      = sys_resetn_q;
    assign heartbeat       = heartbeat_q;
    assign lock_loss_count = loss_q;
    assign state           = STATE_W'(state_q);

endmodule
